pbit_lut_arbiter: RTL and testbench

//  Shares a single tanh-threshold LUT (LUT_bias) among NUM_REQ p-bit update requesters.

---
 rtl/pbit_lut_arbiter_pkg.sv | 56 +++++
 rtl/pbit_lut_arbiter_lut.sv | 40 ++++
 rtl/pbit_lut_arbiter_rr.sv | 46 ++++
 rtl/pbit_lut_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_pbit_lut_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pbit_lut_arbiter_pkg.sv
// ============================================================================
//  Module      : PSL_pkg
//  Description : Shared p-bit datapath constants: input / RNG widths, number
//                of LUT requesters, the response record type and the
//                sigmoid threshold table used by LUT_bias.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package PSL_pkg;

    localparam int i_bit_width   = 6;
    localparam int RNG_bit_width = 32;
    localparam int NUM_PBIT_REQ  = 8;
    localparam int PBIT_ID_W     = $clog2(NUM_PBIT_REQ);

    typedef struct packed {
        logic [PBIT_ID_W-1:0] id;
        logic                 spin;
    } pbit_rsp_t;

    // T(m) = round(2^32 * 1/(1+exp(-m))), clipped to 2^32-1.
    // An input field of magnitude m flips the spin to +1 with probability T(m)/2^32.
    function automatic logic [31:0] lut_bias_entry(input logic [4:0] m);
        logic [31:0] t;
        case (m)
            5'd0:    t = 32'h8000_0000;
            5'd1:    t = 32'hBB26_A7AF;
            5'd2:    t = 32'hE17B_EAD4;
            5'd3:    t = 32'hF3DB_E5E2;
            5'd4:    t = 32'hFB65_4178;
            5'd5:    t = 32'hFE49_6098;
            5'd6:    t = 32'hFF5D_F445;
            5'd7:    t = 32'hFFC4_4B19;
            5'd8:    t = 32'hFFEA_05C2;
            5'd9:    t = 32'hFFF7_E9C8;
            5'd10:   t = 32'hFFFD_065A;
            5'd11:   t = 32'hFFFE_E7CC;
            5'd12:   t = 32'hFFFF_98EB;
            5'd13:   t = 32'hFFFF_DA14;
            5'd14:   t = 32'hFFFF_F20D;
            5'd15:   t = 32'hFFFF_FADE;
            5'd16:   t = 32'hFFFF_FE1D;
            5'd17:   t = 32'hFFFF_FF4E;
            5'd18:   t = 32'hFFFF_FFBF;
            5'd19:   t = 32'hFFFF_FFE8;
            5'd20:   t = 32'hFFFF_FFF7;
            5'd21:   t = 32'hFFFF_FFFD;
            default: t = 32'hFFFF_FFFF;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pbit_lut_arbiter_lut.sv
// ============================================================================
//  Module      : LUT_bias
//  Description : Combinational sigmoid threshold lookup indexed by the input
//                magnitude. Magnitudes beyond the table saturate to all-ones.
//  Ports       : i_mag  input magnitude (IDX_W bits)
//                o_thr  threshold, top T_W bits of the 32-bit table word
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module LUT_bias
    import PSL_pkg::*;
#(
    parameter int IDX_W = 5,
    parameter int T_W   = 32
) (
    input  logic [IDX_W-1:0] i_mag,
    output logic [T_W-1:0]   o_thr
);

    localparam int XW = (IDX_W > 5) ? IDX_W : 5;

    logic [XW-1:0] w_mag_x;
    logic [31:0]   w_t32;

    assign w_mag_x = XW'(i_mag);

    always_comb begin
        if (w_mag_x > XW'(31)) begin
            w_t32 = 32'hFFFF_FFFF;
        end else begin
            w_t32 = lut_bias_entry(w_mag_x[4:0]);
        end
    end

    assign o_thr = w_t32[31 -: T_W];

endmodule

`default_nettype wire

// File: rtl/pbit_lut_arbiter_rr.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin selector. Searches i_req starting
//                at i_ptr, wrapping NUM_REQ-1 -> 0, and returns the first hit.
//  Ports       : i_req  request vector
//                i_ptr  search start index
//                o_gnt  one-hot grant (zero when no request)
//                o_idx  encoded grant index
//                o_any  at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        int k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(i_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = ID_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pbit_lut_arbiter.sv
// ============================================================================
//  Module      : pbit_lut_arbiter
//  Description : Shares one LUT_bias threshold table among NUM_REQ p-bit
//                requesters. Round-robin grant, sign/magnitude split of the
//                granted input, threshold compare against the RNG word sampled
//                in the grant cycle, spin returned with requester id.
//                Latency 2 (3 with LUT_PIPE_EN), one update per clock.
//  Config      : `define LUT_PIPE_EN  registers LUT output, compare operands
//                                      and tags (stage 1b), latency 3.
//  Ports       : clk, rst_n      clock, asynchronous active-low reset
//                i_en            allow new grants
//                i_req           request per p-bit (held until granted)
//                i_req_iin       signed input, slot k = [k*I_W +: I_W]
//                i_rng_in        random word, sampled with the grant
//                o_gnt           one-hot grant, combinational
//                o_rsp_valid     response strobe
//                o_rsp_id        requester index of the response
//                o_rsp_spin      new spin (1 = +1, 0 = -1)
//                o_busy          some pipeline stage holds a valid entry
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pbit_lut_arbiter
    import PSL_pkg::*;
#(
    parameter int NUM_REQ = NUM_PBIT_REQ,
    parameter int I_W     = i_bit_width,
    parameter int RNG_W   = RNG_bit_width,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_en,
    input  logic [NUM_REQ-1:0]     i_req,
    input  logic [NUM_REQ*I_W-1:0] i_req_iin,
    input  logic [RNG_W-1:0]       i_rng_in,
    output logic [NUM_REQ-1:0]     o_gnt,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic                   o_rsp_spin,
    output logic                   o_busy
);

    logic [ID_W-1:0]    r_ptr;
    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [ID_W-1:0]    w_arb_idx;
    logic               w_arb_any;
    logic               w_fire;
    logic [I_W-1:0]     w_sel_iin;
    logic [I_W-1:0]     w_neg_iin;
    logic [I_W-2:0]     w_mag;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // rst_n is in the fire term so gnt stays low for the whole reset interval
    assign w_fire    = rst_n & i_en & w_arb_any;
    assign o_gnt     = w_fire ? w_arb_gnt : '0;
    assign w_sel_iin = i_req_iin[w_arb_idx*I_W +: I_W];
    assign w_neg_iin = ~w_sel_iin + I_W'(1);

    // Negating the most negative value leaves its sign bit set: clamp to max
    always_comb begin
        if (!w_sel_iin[I_W-1]) begin
            w_mag = w_sel_iin[I_W-2:0];
        end else if (w_neg_iin[I_W-1]) begin
            w_mag = '1;
        end else begin
            w_mag = w_neg_iin[I_W-2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_arb_idx == ID_W'(NUM_REQ-1)) ? '0 : w_arb_idx + 1'b1;
        end
    end

    // Stage 1: granted request captured
    logic             r_v1;
    logic [ID_W-1:0]  r_id1;
    logic             r_sgn1;
    logic [I_W-2:0]   r_mag1;
    logic [RNG_W-1:0] r_rng1;
    logic [RNG_W-1:0] w_thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_id1  <= '0;
            r_sgn1 <= 1'b0;
            r_mag1 <= '0;
            r_rng1 <= '0;
        end else begin
            r_v1 <= w_fire;
            if (w_fire) begin
                r_id1  <= w_arb_idx;
                r_sgn1 <= w_sel_iin[I_W-1];
                r_mag1 <= w_mag;
                r_rng1 <= i_rng_in;
            end
        end
    end

    LUT_bias #(
        .IDX_W (I_W-1),
        .T_W   (RNG_W)
    ) u_lut (
        .i_mag (r_mag1),
        .o_thr (w_thr)
    );

    logic             w_dec_v;
    logic [ID_W-1:0]  w_dec_id;
    logic             w_dec_sgn;
    logic [RNG_W-1:0] w_dec_rng;
    logic [RNG_W-1:0] w_dec_thr;
    logic             w_pipe_busy;

`ifdef LUT_PIPE_EN
    // Stage 1b: LUT output and compare operands registered
    logic             r_v1b;
    logic [ID_W-1:0]  r_id1b;
    logic             r_sgn1b;
    logic [RNG_W-1:0] r_rng1b;
    logic [RNG_W-1:0] r_thr1b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1b   <= 1'b0;
            r_id1b  <= '0;
            r_sgn1b <= 1'b0;
            r_rng1b <= '0;
            r_thr1b <= '0;
        end else begin
            r_v1b <= r_v1;
            if (r_v1) begin
                r_id1b  <= r_id1;
                r_sgn1b <= r_sgn1;
                r_rng1b <= r_rng1;
                r_thr1b <= w_thr;
            end
        end
    end

    assign w_dec_v     = r_v1b;
    assign w_dec_id    = r_id1b;
    assign w_dec_sgn   = r_sgn1b;
    assign w_dec_rng   = r_rng1b;
    assign w_dec_thr   = r_thr1b;
    assign w_pipe_busy = r_v1 | r_v1b;
`else
    assign w_dec_v     = r_v1;
    assign w_dec_id    = r_id1;
    assign w_dec_sgn   = r_sgn1;
    assign w_dec_rng   = r_rng1;
    assign w_dec_thr   = w_thr;
    assign w_pipe_busy = r_v1;
`endif

    // A negative field inverts the decision so the spin aligns with the field sign
    logic w_aligned;
    logic w_spin;

    assign w_aligned = (w_dec_rng < w_dec_thr);
    assign w_spin    = w_dec_sgn ? ~w_aligned : w_aligned;

    // Stage 2: response register
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rsp_id;
    logic            r_rsp_spin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_spin  <= 1'b0;
        end else begin
            r_rsp_valid <= w_dec_v;
            if (w_dec_v) begin
                r_rsp_id   <= w_dec_id;
                r_rsp_spin <= w_spin;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_spin  = r_rsp_spin;
    assign o_busy      = w_pipe_busy | r_rsp_valid;

endmodule

`default_nettype wire

// File: tb/tb_pbit_lut_arbiter.sv
// ============================================================================
//  Module      : tb_pbit_lut_arbiter
//  Description : Self-checking bench for pbit_lut_arbiter. A reference
//                round-robin model predicts every grant; each grant pushes
//                the expected {id, spin, grant cycle} into a scoreboard that
//                is popped on every response strobe.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pbit_lut_arbiter;

    localparam int NUM_REQ = 8;
    localparam int I_W     = 6;
    localparam int RNG_W   = 32;
    localparam int ID_W    = 3;
`ifdef LUT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   en = 1'b0;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ*I_W-1:0] req_iin;
    logic [RNG_W-1:0]       rng = '0;
    logic [NUM_REQ-1:0]     o_gnt;
    logic                   o_rsp_valid;
    logic [ID_W-1:0]        o_rsp_id;
    logic                   o_rsp_spin;
    logic                   o_busy;

    logic signed [I_W-1:0] iin_a [NUM_REQ];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mptr    = 0;

    typedef struct {
        int id;
        bit spin;
        int gcyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_iin = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_iin[k*I_W +: I_W] = iin_a[k];
        end
    end

    pbit_lut_arbiter u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (en),
        .i_req       (req),
        .i_req_iin   (req_iin),
        .i_rng_in    (rng),
        .o_gnt       (o_gnt),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_id    (o_rsp_id),
        .o_rsp_spin  (o_rsp_spin),
        .o_busy      (o_busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Only the magnitudes used by the stimulus are tabulated here
    function automatic logic [31:0] ref_thr(input int mag);
        case (mag)
            0:       return 32'h8000_0000;
            1:       return 32'hBB26_A7AF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic bit ref_spin(input logic signed [I_W-1:0] v, input logic [31:0] r);
        int  m;
        bit  al;
        m = int'(v);
        if (m < 0) m = -m;
        if (m > 31) m = 31;
        al = (r < ref_thr(m));
        return (v < 0) ? !al : al;
    endfunction

    // Monitor / reference model, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                mptr = 0;
                check_eq("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
                check_eq("rst_rsp_id",    64'(o_rsp_id),    64'd0);
                check_eq("rst_rsp_spin",  64'(o_rsp_spin),  64'd0);
                check_eq("rst_busy",      64'(o_busy),      64'd0);
                check_eq("rst_gnt",       64'(o_gnt),       64'd0);
            end else begin
                bit                 busy_exp;
                logic [NUM_REQ-1:0] gnt_exp;
                exp_t               e;
                busy_exp = 1'b0;
                foreach (sb[i]) if (sb[i].gcyc < cyc) busy_exp = 1'b1;
                check_eq("busy", 64'(o_busy), 64'(busy_exp));
                if (o_rsp_valid) begin
                    if (sb.size() == 0) begin
                        check_eq("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("rsp_id",      64'(o_rsp_id),   64'(e.id));
                        check_eq("rsp_spin",    64'(o_rsp_spin), 64'(e.spin));
                        check_eq("rsp_latency", 64'(cyc - e.gcyc), 64'(LAT));
                    end
                end
                gnt_exp = '0;
                if (en && (|req)) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        int k;
                        k = (mptr + i) % NUM_REQ;
                        if (gnt_exp == '0 && req[k]) begin
                            gnt_exp[k] = 1'b1;
                            e.id   = k;
                            e.spin = ref_spin(iin_a[k], rng);
                            e.gcyc = cyc;
                            sb.push_back(e);
                            mptr = (k + 1) % NUM_REQ;
                        end
                    end
                end
                check_eq("gnt", 64'(o_gnt), 64'(gnt_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic one_req(input int k, input logic signed [I_W-1:0] v, input logic [31:0] r);
        req      = '0;
        req[k]   = 1'b1;
        iin_a[k] = v;
        rng      = r;
        en       = 1'b1;
        step();
        req = '0;
    endtask

    task automatic randomize_inputs();
        logic signed [I_W-1:0] pick [5];
        pick[0] = 6'sd0;
        pick[1] = 6'sd1;
        pick[2] = -6'sd1;
        pick[3] = -6'sd32;
        pick[4] = 6'sd31;
        for (int k = 0; k < NUM_REQ; k++) begin
            iin_a[k] = pick[$urandom_range(0, 4)];
        end
        rng = $urandom();
    endtask

    initial begin
        logic [NUM_REQ-1:0] oh;
        for (int k = 0; k < NUM_REQ; k++) iin_a[k] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Zero field: threshold 0x8000_0000
        one_req(3, 6'sd0, 32'h7FFF_FFFF);
        one_req(3, 6'sd0, 32'h8000_0000);
        // Unit field, both signs, around T(1) = 0xBB26_A7AF
        one_req(2, 6'sd1,  32'hBB26_A7AE);
        one_req(2, 6'sd1,  32'hBB26_A7AF);
        one_req(2, -6'sd1, 32'hBB26_A7AE);
        one_req(2, -6'sd1, 32'hBB26_A7AF);
        // Most negative input saturates to magnitude 31; requester 7 wraps ptr to 0
        one_req(7, -6'sd32, 32'hFFFF_FFFE);
        one_req(7, -6'sd32, 32'hFFFF_FFFF);
        one_req(7, 6'sd31,  32'hFFFF_FFFE);
        repeat (4) step();

        // Full load: grant order 0..7,0,1 and back-to-back responses
        en  = 1'b1;
        req = '1;
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            #1;
            oh = '0;
            oh[i % NUM_REQ] = 1'b1;
            check_eq("full_load_order", 64'(o_gnt), 64'(oh));
            step();
        end
        req = '0;
        repeat (4) step();

        // en dropped for one cycle mid-burst
        req = '1;
        for (int i = 0; i < 8; i++) begin
            en = (i != 3);
            randomize_inputs();
            if (i == 3) begin
                #1 check_eq("en0_gnt", 64'(o_gnt), 64'd0);
            end
            step();
        end
        req = '0;
        en  = 1'b1;
        repeat (4) step();

        // Reset one cycle after a grant discards the in-flight entry
        one_req(6, 6'sd0, 32'h0000_0001);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        req   = 8'hA0;
        #1 check_eq("rst_first_gnt", 64'(o_gnt), 64'h20);
        step();
        req = 8'h80;
        step();
        req = '0;
        repeat (6) step();
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
        check_eq("idle_busy", 64'(o_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: got 0x0 expected 0x1");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
